// File: rtl/block_nest_checker.sv
// Checks begin/end and case/endcase nesting in an ASCII stream, one character per accepted cycle.
// A keyword commits on the space that ends it; result also reflects the pending word.
module block_nest_checker #(
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned DW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          result,
  output logic          error,
  output logic          overflow,
  output logic [DW-1:0] depth
);

  localparam logic [DW-1:0] MaxDepthW = DW'(MAX_DEPTH);
  localparam int unsigned   WordLen   = 7;

  typedef enum logic [2:0] {KwNone, KwBegin, KwEnd, KwCase, KwEndcase} kw_e;

  logic [WordLen-1:0][7:0] word_q, word_d;
  logic [3:0]              len_q, len_d;
  logic [DW-1:0]           depth_q, depth_d;
  logic                    error_q, error_d;
  logic                    overflow_q, overflow_d;
  logic [MAX_DEPTH-1:0]    stack_q, stack_d;

  logic       is_space;
  logic [7:0] lc_char;
  kw_e        pending_kw;
  logic       kw_open, kw_close, kw_type;
  logic       top_type, full, empty, close_ok, open_ok;
  logic       eff_ok;
  logic [DW-1:0] eff_depth;

  assign is_space = (in == 8'h20);
  assign lc_char  = (in >= 8'h41 && in <= 8'h5a) ? (in | 8'h20) : in;

  // Buffer only holds 7 characters; a saturated length of 8 can never match a keyword.
  always_comb begin
    pending_kw = KwNone;
    unique case (len_q)
      4'd3: if ({word_q[0], word_q[1], word_q[2]} == "end") pending_kw = KwEnd;
      4'd4: if ({word_q[0], word_q[1], word_q[2], word_q[3]} == "case") pending_kw = KwCase;
      4'd5: if ({word_q[0], word_q[1], word_q[2], word_q[3], word_q[4]} == "begin") begin
        pending_kw = KwBegin;
      end
      4'd7: if ({word_q[0], word_q[1], word_q[2], word_q[3], word_q[4], word_q[5],
                 word_q[6]} == "endcase") begin
        pending_kw = KwEndcase;
      end
      default: pending_kw = KwNone;
    endcase
  end

  assign kw_open  = (pending_kw == KwBegin) || (pending_kw == KwCase);
  assign kw_close = (pending_kw == KwEnd) || (pending_kw == KwEndcase);
  assign kw_type  = (pending_kw == KwCase) || (pending_kw == KwEndcase);

  always_comb begin
    top_type = 1'b0;
    for (int i = 0; i < int'(MAX_DEPTH); i++) begin
      if (depth_q == DW'(i + 1)) top_type = stack_q[i];
    end
  end

  assign full     = (depth_q == MaxDepthW);
  assign empty    = (depth_q == '0);
  assign open_ok  = kw_open && !full;
  assign close_ok = kw_close && !empty && (top_type == kw_type);

  assign eff_ok    = !(kw_open && full) && !(kw_close && !close_ok);
  assign eff_depth = open_ok  ? depth_q + DW'(1) :
                     close_ok ? depth_q - DW'(1) : depth_q;

  always_comb begin
    word_d     = word_q;
    len_d      = len_q;
    depth_d    = depth_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    stack_d    = stack_q;
    if (in_valid) begin
      if (is_space) begin
        len_d = 4'd0;
        if (open_ok) begin
          for (int i = 0; i < int'(MAX_DEPTH); i++) begin
            if (depth_q == DW'(i)) stack_d[i] = kw_type;
          end
          depth_d = depth_q + DW'(1);
        end else if (kw_open) begin
          overflow_d = 1'b1;
          error_d    = 1'b1;
        end else if (close_ok) begin
          depth_d = depth_q - DW'(1);
        end else if (kw_close) begin
          error_d = 1'b1;
        end
      end else begin
        for (int i = 0; i < int'(WordLen); i++) begin
          if (len_q == 4'(i)) word_d[i] = lc_char;
        end
        if (len_q != 4'd8) len_d = len_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= 4'd0;
      depth_q    <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      len_q      <= len_d;
      depth_q    <= depth_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  // Contents are gated by len_q/depth_q, so they need no reset.
  always_ff @(posedge clk) begin
    word_q  <= word_d;
    stack_q <= stack_d;
  end

  assign result   = !error_q && eff_ok && (eff_depth == '0);
  assign error    = error_q;
  assign overflow = overflow_q;
  assign depth    = depth_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed bench for block_nest_checker: string-driven vector table plus corner-case sequences.
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       result, error, overflow;
  logic [3:0] depth;
  logic       result2, error2, overflow2;
  logic [1:0] depth2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  block_nest_checker #(.MAX_DEPTH(8), .DW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(result), .error(error), .overflow(overflow), .depth(depth)
  );

  block_nest_checker #(.MAX_DEPTH(2), .DW(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(result2), .error(error2), .overflow(overflow2), .depth(depth2)
  );

  typedef struct {
    bit    rst;
    string s;
    bit    r;
    bit    e;
    bit    o;
    int    d;
  } vec_t;

  task automatic check(input string name, input bit r, input bit e, input bit o, input int d,
                       input bit r_x, input bit e_x, input bit o_x, input int d_x);
    n_vec++;
    if (r !== r_x || e !== e_x || o !== o_x || d != d_x) begin
      n_bad++;
      $display("FAIL %s: got result=%0b error=%0b overflow=%0b depth=%0d, want %0b %0b %0b %0d",
               name, r, e, o, d, r_x, e_x, o_x, d_x);
    end
  endtask

  task automatic chk(input string name, input bit r_x, input bit e_x, input bit o_x,
                     input int d_x);
    check(name, result, error, overflow, int'(depth), r_x, e_x, o_x, d_x);
  endtask

  task automatic chk2(input string name, input bit r_x, input bit e_x, input bit o_x,
                      input int d_x);
    check(name, result2, error2, overflow2, int'(depth2), r_x, e_x, o_x, d_x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      in       = s[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in = 8'h20;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1, "begin",    0, 0, 0, 0},
      '{0, " ",        0, 0, 0, 1},
      '{0, "case ",    0, 0, 0, 2},
      '{0, "x ",       0, 0, 0, 2},
      '{0, "endcase",  0, 0, 0, 2},
      '{0, " ",        0, 0, 0, 1},
      '{0, "end",      1, 0, 0, 1},
      '{0, " ",        1, 0, 0, 0},
      '{0, "BEGIN EnD", 1, 0, 0, 1},
      '{0, "x",        0, 0, 0, 1},
      '{0, " ",        0, 0, 0, 1},
      '{1, "begin endcase", 0, 0, 0, 1},
      '{0, " ",        0, 1, 0, 1},
      '{0, "end ",     0, 1, 0, 0},
      '{1, "end ",     0, 1, 0, 0},
      '{0, "begins begi endcases endc beg ", 0, 1, 0, 0},
      '{1, "endcaseendcase", 1, 0, 0, 0},
      '{0, " ",        1, 0, 0, 0},
      '{0, "  case  ", 0, 0, 0, 1},
      '{0, "eNdCaSe", 1, 0, 0, 1}
    };

    do_reset();
    @(negedge clk);
    chk("reset", 1, 0, 0, 0);
    chk2("reset2", 1, 0, 0, 0);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      send_str(vecs[k].s);
      chk($sformatf("vec%0d", k), vecs[k].r, vecs[k].e, vecs[k].o, vecs[k].d);
    end

    // Shallow stack overflow, then pops continue while error stays sticky.
    do_reset();
    send_str("begin begin ");
    chk2("ovf_full", 0, 0, 0, 2);
    send_str("begin");
    chk2("ovf_pending", 0, 0, 0, 2);
    send_str(" ");
    chk2("ovf_commit", 0, 1, 1, 2);
    chk("deep_no_ovf", 0, 0, 0, 3);
    send_str("end end ");
    chk2("ovf_drain", 0, 1, 1, 0);
    chk("deep_drain", 0, 0, 0, 1);

    // Deep instance overflow at exactly MAX_DEPTH.
    do_reset();
    send_str("begin begin begin begin case case case case ");
    chk("deep_full", 0, 0, 0, 8);
    send_str("case ");
    chk("deep_ovf", 0, 1, 1, 8);

    // Idle cycles with a space on in must not commit.
    do_reset();
    send_str("begin");
    idle(3);
    chk("idle_hold", 0, 0, 0, 0);
    send_str(" ");
    chk("idle_commit", 0, 0, 0, 1);

    // Asynchronous reset mid-word, between clock edges.
    do_reset();
    send_str("end begin begi");
    chk("pre_async", 0, 1, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_clear", 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("async_held", 1, 0, 0, 0);
    #2;
    reset = 1'b0;
    send_str("n ");
    chk("post_reset_word", 1, 0, 0, 0);
    send_str("end ");
    chk("post_reset_end", 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/block_nest_checker.md
BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

Interface
REQ-001 Parameter MAX_DEPTH, default 8: maximum simultaneous open blocks held on the type stack (legal range 1..255).
REQ-002 Parameter DW, default 4: width of the depth output; the instantiator SHALL pick DW so that 2^DW > MAX_DEPTH.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  high when in carries a character this cycle; low means no state change.
REQ-006 in  input  8  ASCII character of the input stream.
REQ-007 result  output  1  high when the stream so far, including any pending word, is balanced and error-free.
REQ-008 error  output  1  sticky: a mismatched close, an unmatched close or an overflow has been committed.
REQ-009 overflow  output  1  sticky: an open was committed while the stack held MAX_DEPTH entries.
REQ-010 depth  output  DW  number of committed open blocks.

Function
REQ-011 Word: maximal run of non-space characters; space is 8'h20 only; every other byte is a word character.
REQ-012 Keywords, case-insensitive: "begin" opens type 0; "end" closes type 0; "case" opens type 1; "endcase" closes type 1.
REQ-013 Pending word: characters accepted since the last space; pending_kw is the keyword exactly equal to it, else none; any word longer than 7 characters never matches; word length counter saturates at 8.
REQ-014 Non-space accepted (in_valid=1): appended to the pending word; stack, depth, error and overflow are unchanged.
REQ-015 Space accepted: commits pending_kw, then clears the pending word; consecutive spaces commit nothing.
REQ-016 Commit open with depth<MAX_DEPTH: push type, depth+1 in the same clock edge.
REQ-017 Commit open with depth==MAX_DEPTH: stack and depth unchanged; overflow<=1; error<=1.
REQ-018 Commit close with depth>0 and top type equal to the close type: pop, depth-1.
REQ-019 Commit close with depth==0 or top type mismatched: stack and depth unchanged; error<=1.
REQ-020 Committing a non-keyword word, or a prefix such as "beg" or "endc", changes nothing.
REQ-021 Once set, error and overflow remain set until reset; later commits still update the stack and depth per REQ-016..REQ-019.
REQ-022 Tentative view, combinational over committed state and pending_kw: eff_ok=0 if pending_kw is an open and depth==MAX_DEPTH, or pending_kw is a close that would fail REQ-019; otherwise eff_ok=1.
REQ-023 Tentative depth: eff_depth = depth+1 for a legal pending open, depth-1 for a legal pending close, else depth.
REQ-024 result = !error && eff_ok && (eff_depth==0); result is purely combinational, with zero latency from the last accepted character.
REQ-025 in_valid=0: all registers hold; outputs change only on a rising clk edge or on reset.
REQ-026 Stack storage is MAX_DEPTH one-bit entries addressed by depth; no entry above depth affects any output.

Reset
REQ-027 Asserting reset SHALL asynchronously force depth=0, error=0, overflow=0, pending word empty, so result=1 while reset is held, including mid-word or mid-stream.
REQ-028 After reset deassertion, the first accepted character is treated as the start of a new word.
REQ-029 Stack entry contents need not be reset; REQ-026 guarantees they are invisible.

Verification
REQ-030 "begin case x endcase end " -> depth sequence 1,2,1,0; result=1 after the final space; error=0.
REQ-031 "begin endcase " -> result=0 while "endcase" is pending; error=1 after the space; depth stays 1; result stays 0.
REQ-032 "BEGIN EnD" with no trailing space -> result=1 after 'D'; then 'x' -> result=0; then space -> depth=1, result=0.
REQ-033 MAX_DEPTH=2, "begin begin begin " -> depth=2, overflow=1, error=1 after the third space; later "end end " -> depth=0, result still 0.
REQ-034 "end " at start -> error=1; "begins begi endcases " -> no depth change.
REQ-035 Reset asserted mid-word after "begi", between clock edges -> outputs clear immediately; "end " afterwards -> error=1; in_valid=0 cycles inserted anywhere -> no change.
